// File: rtl/lcd_sync_lock.sv
// lcd_sync_lock
//   Front end of the LCD-to-VGA path. Samples the raw LCD sync and 1-bit RGB
//   on the pixel clock, drops sync edges that arrive too soon after the last
//   accepted one, measures the frame period and declares lock once enough
//   consecutive periods agree within a tolerance.
// Ports
//   iw_clk, iw_rst          pixel clock, asynchronous active-high reset
//   iw_sync                 raw LCD sync
//   iw_r0/g0/b0             raw pixel bits
//   ow_r0/g0/b0             pixel bits delayed two cycles (aligned with ow_frame_start)
//   ow_frame_start          one-cycle pulse per accepted sync edge
//   ow_locked               high while locked
//   ow_lock_lost            one-cycle pulse when leaving the locked state
//   ow_period               reference frame period in clock ticks
module lcd_sync_lock #(
  parameter int          P_CNT_W       = 20,
  parameter int          P_MIN_PERIOD  = 1000,
  parameter int          P_TOL         = 8,
  parameter int          P_LOCK_FRAMES = 3,
  parameter int unsigned P_TIMEOUT     = (1 << 20) - 1
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_sync,
  input  logic               iw_r0,
  input  logic               iw_g0,
  input  logic               iw_b0,
  output logic               ow_r0,
  output logic               ow_g0,
  output logic               ow_b0,
  output logic               ow_frame_start,
  output logic               ow_locked,
  output logic               ow_lock_lost,
  output logic [P_CNT_W-1:0] ow_period
);

  localparam int MC_W = $clog2(P_LOCK_FRAMES + 1);
  localparam logic [P_CNT_W-1:0] TMO  = P_CNT_W'(P_TIMEOUT);
  localparam logic [P_CNT_W-1:0] MINP = P_CNT_W'(P_MIN_PERIOD);
  localparam logic [P_CNT_W:0]   TOL  = (P_CNT_W + 1)'(P_TOL);
  localparam logic [MC_W-1:0]    LOCKN = MC_W'(P_LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [MC_W-1:0]    mcnt_q, mcnt_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [P_CNT_W-1:0] per_q, per_d;
  logic               s1_q, s2_q;
  logic [2:0]         rgb1_q, rgb2_q;
  logic               fs_q, locked_q, lost_q, lost_d;

  logic               sync_edge, acc, tmo, match;
  logic [P_CNT_W-1:0] period;
  logic [P_CNT_W:0]   diff, adiff;

  assign sync_edge = s1_q & ~s2_q;
  assign tmo       = (cnt_q == TMO);
  // Saturated counter: the period never wraps past the timeout value.
  assign period    = tmo ? TMO : cnt_q + 1'b1;
  assign acc       = sync_edge && ((state_q == SEARCH) || (period >= MINP));

  // One extra bit keeps the signed difference of two unsigned periods exact.
  assign diff  = {1'b0, period} - {1'b0, per_q};
  assign adiff = diff[P_CNT_W] ? (~diff + 1'b1) : diff;
  assign match = (adiff <= TOL);

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    per_d   = per_q;
    lost_d  = 1'b0;
    cnt_d   = acc ? '0 : (tmo ? cnt_q : cnt_q + 1'b1);
    unique case (state_q)
      SEARCH: begin
        if (acc) begin
          state_d = ACQUIRE;
          mcnt_d  = '0;
        end
      end
      ACQUIRE: begin
        if (acc) begin
          per_d = period;
          if (mcnt_q == '0) begin
            mcnt_d = MC_W'(1);
            if (LOCKN == MC_W'(1)) state_d = LOCKED;
          end else if (match) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q + 1'b1 == LOCKN) state_d = LOCKED;
          end else begin
            mcnt_d = MC_W'(1);
          end
        end else if (tmo) begin
          state_d = SEARCH;
          mcnt_d  = '0;
        end
      end
      LOCKED: begin
        if (acc) begin
          per_d = period;  // track slow drift while locked
          if (!match) begin
            state_d = ACQUIRE;
            mcnt_d  = MC_W'(1);
            lost_d  = 1'b1;
          end
        end else if (tmo) begin
          state_d = SEARCH;
          mcnt_d  = '0;
          lost_d  = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        mcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q  <= SEARCH;
      mcnt_q   <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      rgb1_q   <= '0;
      rgb2_q   <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      s1_q     <= iw_sync;
      s2_q     <= s1_q;
      rgb1_q   <= {iw_r0, iw_g0, iw_b0};
      rgb2_q   <= rgb1_q;
      fs_q     <= acc;
      // From next state so lock rises together with the locking frame start.
      locked_q <= (state_d == LOCKED);
      lost_q   <= lost_d;
    end
  end

  assign {ow_r0, ow_g0, ow_b0} = rgb2_q;
  assign ow_frame_start        = fs_q;
  assign ow_locked             = locked_q;
  assign ow_lock_lost          = lost_q;
  assign ow_period             = per_q;

endmodule

// File: tb/tb_lcd_sync_lock.sv
module tb_lcd_sync_lock;
  localparam int W = 10;
  localparam logic [W-1:0] TP = 10'd400;

  logic iw_clk = 1'b0, iw_rst = 1'b1, iw_sync = 1'b0;
  logic iw_r0 = 1'b0, iw_g0 = 1'b0, iw_b0 = 1'b0;
  logic ow_r0, ow_g0, ow_b0, ow_frame_start, ow_locked, ow_lock_lost;
  logic [W-1:0] ow_period;

  lcd_sync_lock #(
    .P_CNT_W(W), .P_MIN_PERIOD(100), .P_TOL(8), .P_LOCK_FRAMES(3), .P_TIMEOUT(1023)
  ) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_sync(iw_sync),
    .iw_r0(iw_r0), .iw_g0(iw_g0), .iw_b0(iw_b0),
    .ow_r0(ow_r0), .ow_g0(ow_g0), .ow_b0(ow_b0),
    .ow_frame_start(ow_frame_start), .ow_locked(ow_locked),
    .ow_lock_lost(ow_lock_lost), .ow_period(ow_period)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    logic         lk;
    logic [W-1:0] per;
    logic [2:0]   rgb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0, lost_cnt = 0;

  // Scoreboard: every frame_start pops the expectation pushed at its sync edge.
  always @(negedge iw_clk) begin
    if (ow_lock_lost) lost_cnt++;
    if (ow_frame_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL frame_start_unexpected at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({ow_locked, ow_period, ow_r0, ow_g0, ow_b0} !== {e.lk, e.per, e.rgb}) begin
          failures++;
          $display("FAIL frame lock/period/rgb got %0b/%0d/%03b expected %0b/%0d/%03b at %0t",
                   ow_locked, ow_period, {ow_r0, ow_g0, ow_b0}, e.lk, e.per, e.rgb, $time);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge iw_clk);
    #1;
  endtask

  // Raise sync now; the next rise happens exactly gap clocks later.
  task automatic frame(input int gap, input logic lk, input logic [W-1:0] per,
                       input logic [2:0] rgb, input bit glitch);
    int used;
    exp_t e;
    e.lk = lk; e.per = per; e.rgb = rgb;
    exp_q.push_back(e);
    iw_sync = 1'b1;
    {iw_r0, iw_g0, iw_b0} = rgb;
    cyc(1);
    {iw_r0, iw_g0, iw_b0} = 3'b000;
    cyc(2);
    iw_sync = 1'b0;
    used = 3;
    if (glitch) begin
      for (int k = 0; k < 3; k++) begin
        int o;
        o = 20 + 30 * k;
        cyc(o - used);
        iw_sync = 1'b1;
        cyc(2);
        iw_sync = 1'b0;
        used = o + 2;
      end
    end
    cyc(gap - used);
  endtask

  function automatic logic [2:0] rnd3();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      iw_sync = i[0];
      {iw_r0, iw_g0, iw_b0} = 3'b111;
      cyc(1);
      checks++;
      if ({ow_frame_start, ow_locked, ow_lock_lost, ow_period, ow_r0, ow_g0, ow_b0} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got fs=%0b lk=%0b lost=%0b per=%0d rgb=%03b expected all 0",
                 ow_frame_start, ow_locked, ow_lock_lost, ow_period, {ow_r0, ow_g0, ow_b0});
      end
    end
    iw_sync = 1'b0;
    {iw_r0, iw_g0, iw_b0} = 3'b000;
    cyc(1);
    iw_rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_acquire();
    int l0;
    l0 = lost_cnt;
    frame(400, 1'b0, 10'd0, rnd3(), 1'b0);
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b1, TP, rnd3(), 1'b0);
    frame(400, 1'b1, TP, rnd3(), 1'b0);
    checks++;
    if (ow_locked !== 1'b1 || ow_period !== TP) begin
      failures++;
      $display("FAIL acquire_lock got lk=%0b per=%0d expected lk=1 per=%0d", ow_locked, ow_period, TP);
    end
    checks++;
    if (lost_cnt - l0 != 0) begin
      failures++;
      $display("FAIL acquire_no_lost got %0d pulses expected 0", lost_cnt - l0);
    end
  endtask

  task automatic test_glitch();
    frame(400, 1'b1, TP, rnd3(), 1'b1);
    frame(400, 1'b1, TP, rnd3(), 1'b1);
    checks++;
    if (ow_locked !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_hold got lk=%0b pending=%0d expected lk=1 pending=0", ow_locked, exp_q.size());
    end
  endtask

  task automatic test_drift();
    frame(405, 1'b1, TP, rnd3(), 1'b0);
    frame(397, 1'b1, 10'd405, rnd3(), 1'b0);
    frame(400, 1'b1, 10'd397, rnd3(), 1'b0);   // |397-405| = 8, edge of tolerance
    frame(400, 1'b1, TP, rnd3(), 1'b0);
    checks++;
    if (ow_locked !== 1'b1 || ow_period !== TP) begin
      failures++;
      $display("FAIL drift_track got lk=%0b per=%0d expected lk=1 per=%0d", ow_locked, ow_period, TP);
    end
  endtask

  task automatic test_relock();
    int l0;
    l0 = lost_cnt;
    frame(500, 1'b1, TP, rnd3(), 1'b0);
    frame(500, 1'b0, 10'd500, rnd3(), 1'b0);
    frame(500, 1'b0, 10'd500, rnd3(), 1'b0);
    frame(500, 1'b1, 10'd500, rnd3(), 1'b0);
    checks++;
    if (lost_cnt - l0 != 1) begin
      failures++;
      $display("FAIL relock_lost_pulses got %0d expected 1", lost_cnt - l0);
    end
    checks++;
    if (ow_locked !== 1'b1 || ow_period !== 10'd500) begin
      failures++;
      $display("FAIL relock_state got lk=%0b per=%0d expected lk=1 per=500", ow_locked, ow_period);
    end
  endtask

  task automatic test_timeout();
    int n, l0;
    frame(400, 1'b1, 10'd500, rnd3(), 1'b0);
    l0 = lost_cnt;
    n = 0;
    while (!ow_lock_lost && n < 1200) begin
      @(negedge iw_clk);
      n++;
    end
    checks++;
    if (ow_lock_lost !== 1'b1 || n != 627) begin
      failures++;
      $display("FAIL timeout_pulse got lost=%0b after %0d cycles expected lost=1 after 627", ow_lock_lost, n);
    end
    checks++;
    if (ow_locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_unlock got lk=%0b expected 0", ow_locked);
    end
    @(negedge iw_clk);
    checks++;
    if (ow_lock_lost !== 1'b0 || lost_cnt - l0 != 1) begin
      failures++;
      $display("FAIL timeout_one_pulse got lost=%0b count=%0d expected lost=0 count=1",
               ow_lock_lost, lost_cnt - l0);
    end
    cyc(1);
    frame(400, 1'b0, 10'd500, rnd3(), 1'b0);   // SEARCH keeps the old reference
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b1, TP, rnd3(), 1'b0);
  endtask

  task automatic test_pixel_reset();
    int l0;
    l0 = lost_cnt;
    frame(400, 1'b1, TP, 3'b101, 1'b0);
    frame(400, 1'b1, TP, 3'b010, 1'b0);
    {iw_r0, iw_g0, iw_b0} = 3'b111;
    cyc(100);
    checks++;
    if ({ow_r0, ow_g0, ow_b0} !== 3'b111 || ow_locked !== 1'b1) begin
      failures++;
      $display("FAIL pixel_passthru got rgb=%03b lk=%0b expected rgb=111 lk=1", {ow_r0, ow_g0, ow_b0}, ow_locked);
    end
    #2;
    iw_rst = 1'b1;
    #1;
    checks++;
    if ({ow_frame_start, ow_locked, ow_lock_lost, ow_period, ow_r0, ow_g0, ow_b0} !== '0) begin
      failures++;
      $display("FAIL midframe_reset got lk=%0b per=%0d rgb=%03b expected all 0",
               ow_locked, ow_period, {ow_r0, ow_g0, ow_b0});
    end
    {iw_r0, iw_g0, iw_b0} = 3'b000;
    cyc(3);
    iw_rst = 1'b0;
    cyc(2);
    frame(400, 1'b0, 10'd0, rnd3(), 1'b0);
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b0, TP, rnd3(), 1'b0);
    frame(400, 1'b1, TP, rnd3(), 1'b0);
    checks++;
    if (lost_cnt - l0 != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_relock got lost=%0d pending=%0d expected 0/0", lost_cnt - l0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_glitch();
    test_drift();
    test_relock();
    test_timeout();
    test_pixel_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
